// File: rtl/ed2_timer_pkg.sv
// Shared register offsets and control-bit positions for the multi-channel timer.
`timescale 1ns/1ps
package ed2_timer_pkg;

  typedef enum logic [2:0] {
    REG_STATUS   = 3'd0,
    REG_CONTROL  = 3'd1,
    REG_PERIOD_L = 3'd2,
    REG_PERIOD_H = 3'd3,
    REG_SNAP_L   = 3'd4,
    REG_SNAP_H   = 3'd5,
    REG_PRESC    = 3'd6,
    REG_IRQ_PEND = 3'd7
  } timer_reg_e;

  localparam int CTL_ITO   = 0;
  localparam int CTL_CONT  = 1;
  localparam int CTL_START = 2;
  localparam int CTL_STOP  = 3;

endpackage

// File: rtl/ed2_multi_timer_if.sv
// Avalon-MM 16-bit slave bus of the multi-channel timer.
`timescale 1ns/1ps
interface ed2_multi_timer_if #(
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [15:0]       writedata;
    logic [15:0]       readdata;

    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/ed2_timer_channel.sv
// One timer channel: prescaler, down-counter, period/snapshot/control registers
// and a combinational read mux for its register window.
`timescale 1ns/1ps
module ed2_timer_channel
    import ed2_timer_pkg::*;
#(
    parameter int          COUNT_W        = 32,
    parameter logic [31:0] DEFAULT_PERIOD = 32'h1869F
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        wr,
    input  logic [2:0]  reg_sel,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        irq_out
);

    localparam logic [COUNT_W-1:0] RST_PERIOD = DEFAULT_PERIOD[COUNT_W-1:0];

    logic [COUNT_W-1:0] counter, period, snapshot;
    logic [3:0]         ctl;
    logic [15:0]        presc, pcnt;
    logic               to, run, reload_pend;

    logic wr_status, wr_ctl, wr_period, wr_snap, wr_presc;
    logic start, stop, tick, expire;

    always_comb begin
        wr_status = wr && (reg_sel == REG_STATUS);
        wr_ctl    = wr && (reg_sel == REG_CONTROL);
        wr_period = wr && ((reg_sel == REG_PERIOD_L) || (reg_sel == REG_PERIOD_H));
        wr_snap   = wr && ((reg_sel == REG_SNAP_L) || (reg_sel == REG_SNAP_H));
        wr_presc  = wr && (reg_sel == REG_PRESC);
        start     = wr_ctl && wdata[CTL_START];
        stop      = wr_ctl && wdata[CTL_STOP] && !start;
        // a START or a pending period reload owns the prescaler this cycle
        tick      = run && (pcnt == 16'd0) && !start && !reload_pend;
        expire    = tick && (counter == '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            period      <= RST_PERIOD;
            ctl         <= '0;
            presc       <= '0;
            snapshot    <= '0;
            reload_pend <= 1'b0;
        end else begin
            reload_pend <= wr_period;
            if (wr && reg_sel == REG_PERIOD_L) period[15:0] <= wdata;
            if (wr && reg_sel == REG_PERIOD_H) period[COUNT_W-1:16] <= wdata[COUNT_W-17:0];
            if (wr_ctl)   ctl      <= wdata[3:0];
            if (wr_presc) presc    <= wdata;
            if (wr_snap)  snapshot <= counter;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            counter <= RST_PERIOD;
            pcnt    <= '0;
        end else begin
            if (start || reload_pend) pcnt <= presc;
            else if (run)             pcnt <= (pcnt == 16'd0) ? presc : pcnt - 16'd1;

            if (reload_pend)  counter <= period;
            else if (expire)  counter <= period;
            else if (tick)    counter <= counter - COUNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run <= 1'b0;
            to  <= 1'b0;
        end else begin
            if (start)                          run <= 1'b1;
            else if (reload_pend || stop)       run <= 1'b0;
            else if (expire && !ctl[CTL_CONT])  run <= 1'b0;

            // software clear beats a timeout landing in the same cycle
            if (wr_status)   to <= 1'b0;
            else if (expire) to <= 1'b1;
        end
    end

    assign irq_out = to & ctl[CTL_ITO];

    always_comb begin
        rdata = '0;
        case (timer_reg_e'(reg_sel))
            REG_STATUS:   rdata = {14'd0, run, to};
            REG_CONTROL:  rdata = {12'd0, ctl};
            REG_PERIOD_L: rdata = period[15:0];
            REG_PERIOD_H: rdata[COUNT_W-17:0] = period[COUNT_W-1:16];
            REG_SNAP_L:   rdata = snapshot[15:0];
            REG_SNAP_H:   rdata[COUNT_W-17:0] = snapshot[COUNT_W-1:16];
            REG_PRESC:    rdata = presc;
            default:      rdata = '0;
        endcase
    end

endmodule

// File: rtl/ed2_multi_timer.sv
// Multi-channel interval timer: address decode, registered read path and irq
// aggregation around an array of ed2_timer_channel instances.
`timescale 1ns/1ps
module ed2_multi_timer
    import ed2_timer_pkg::*;
#(
    parameter int          NUM_CH         = 4,
    parameter int          COUNT_W        = 32,
    parameter logic [31:0] DEFAULT_PERIOD = 32'h1869F,
    localparam int         CH_AW          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    ed2_multi_timer_if.slave  bus,
    output logic [NUM_CH-1:0] irq_vec,
    output logic              irq
);

    logic [CH_AW-1:0]             ch_sel;
    logic [2:0]                   reg_sel;
    logic                         wr_en;
    logic [NUM_CH-1:0][15:0]      ch_rdata;
    logic [15:0]                  rd_next;

    assign ch_sel  = bus.address[CH_AW+2:3];
    assign reg_sel = bus.address[2:0];
    assign wr_en   = bus.chipselect && !bus.write_n;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        ed2_timer_channel #(
            .COUNT_W        (COUNT_W),
            .DEFAULT_PERIOD (DEFAULT_PERIOD)
        ) u_ch (
            .clk     (clk),
            .reset_n (reset_n),
            .wr      (wr_en && (ch_sel == CH_AW'(i))),
            .reg_sel (reg_sel),
            .wdata   (bus.writedata),
            .rdata   (ch_rdata[i]),
            .irq_out (irq_vec[i])
        );
    end

    // irq_pend is global, but an unpopulated channel slot still reads zero
    always_comb begin
        rd_next = '0;
        if (int'(ch_sel) < NUM_CH) begin
            if (reg_sel == REG_IRQ_PEND) rd_next = 16'(irq_vec);
            else                         rd_next = ch_rdata[ch_sel];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                             bus.readdata <= '0;
        else if (bus.chipselect && bus.write_n)   bus.readdata <= rd_next;
    end

    assign irq = |irq_vec;

endmodule

// File: tb/tb_ed2_multi_timer.sv
// Bench for ed2_multi_timer: directed scenarios with hand-computed values plus
// random bus traffic, all outputs compared every cycle against a cycle model.
`timescale 1ns/1ps
module tb_ed2_multi_timer;

    localparam int NUM_CH = 4;
    localparam int CH_AW  = 2;
    localparam logic [31:0] DEF_P = 32'h1869F;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [NUM_CH-1:0] irq_vec;
    logic irq;

    ed2_multi_timer_if #(.ADDR_W(CH_AW+3)) bus();

    ed2_multi_timer #(.NUM_CH(NUM_CH), .COUNT_W(32), .DEFAULT_PERIOD(DEF_P)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus), .irq_vec(irq_vec), .irq(irq)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // bus inputs as seen by the rising edge
    logic              s_rst, s_cs, s_wn;
    logic [CH_AW+2:0]  s_addr;
    logic [15:0]       s_wd;
    always @(posedge clk) begin
        s_rst  <= reset_n;
        s_cs   <= bus.chipselect;
        s_wn   <= bus.write_n;
        s_addr <= bus.address;
        s_wd   <= bus.writedata;
    end

    // reference state per channel
    bit [31:0] m_cnt[NUM_CH], m_per[NUM_CH], m_snap[NUM_CH];
    int        m_ctl[NUM_CH], m_ps[NUM_CH], m_pc[NUM_CH];
    bit        m_to[NUM_CH], m_run[NUM_CH], m_pend[NUM_CH];
    logic [15:0] m_rd;

    function automatic logic [NUM_CH-1:0] m_irqv();
        logic [NUM_CH-1:0] v;
        v = '0;
        for (int c = 0; c < NUM_CH; c++) v[c] = m_to[c] & m_ctl[c][0];
        return v;
    endfunction

    function automatic logic [15:0] m_read(input int c, input int rg);
        if (c >= NUM_CH) return 16'h0;
        case (rg)
            0: return {14'd0, m_run[c], m_to[c]};
            1: return 16'(m_ctl[c]);
            2: return m_per[c][15:0];
            3: return m_per[c][31:16];
            4: return m_snap[c][15:0];
            5: return m_snap[c][31:16];
            6: return 16'(m_ps[c]);
            default: return 16'(m_irqv());
        endcase
    endfunction

    task automatic m_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_cnt[c] = DEF_P; m_per[c] = DEF_P; m_snap[c] = 0;
            m_ctl[c] = 0; m_ps[c] = 0; m_pc[c] = 0;
            m_to[c] = 0; m_run[c] = 0; m_pend[c] = 0;
        end
        m_rd = 16'h0;
    endtask

    task automatic m_step();
        int ch, rg;
        bit w, wc, go, halt, tick, tmo;
        ch = int'(s_addr >> 3);
        rg = int'(s_addr & 5'd7);
        w  = s_cs && !s_wn;
        if (s_cs && s_wn) m_rd = m_read(ch, rg);
        for (int c = 0; c < NUM_CH; c++) begin
            wc   = w && (ch == c);
            go   = wc && rg == 1 && s_wd[2];
            halt = wc && rg == 1 && s_wd[3] && !go;
            // a counting step happens when the prescaler has run out and nobody reloads it
            tick = m_run[c] && m_pc[c] == 0 && !go && !m_pend[c];
            tmo  = tick && m_cnt[c] == 0;
            if (wc && (rg == 4 || rg == 5)) m_snap[c] = m_cnt[c];
            if (m_pend[c] || tmo) m_cnt[c] = m_per[c];
            else if (tick)        m_cnt[c] = m_cnt[c] - 1;
            if (go || m_pend[c])  m_pc[c] = m_ps[c];
            else if (m_run[c])    m_pc[c] = (m_pc[c] == 0) ? m_ps[c] : m_pc[c] - 1;
            if (go)                          m_run[c] = 1;
            else if (m_pend[c] || halt)      m_run[c] = 0;
            else if (tmo && !m_ctl[c][1])    m_run[c] = 0;
            if (wc && rg == 0) m_to[c] = 0;
            else if (tmo)      m_to[c] = 1;
            m_pend[c] = wc && (rg == 2 || rg == 3);
            if (wc && rg == 2) m_per[c][15:0]  = s_wd;
            if (wc && rg == 3) m_per[c][31:16] = s_wd;
            if (wc && rg == 1) m_ctl[c] = int'(s_wd[3:0]);
            if (wc && rg == 6) m_ps[c]  = int'(s_wd);
        end
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%h, expected 0x%h at %0t", nm, act, exp, $time);
        end
    endtask

    // literal expectations posted by the stimulus, checked on the next falling edge
    int          lit_seq = 0, lit_done = 0, lit_kind = 0;
    logic [15:0] lit_val = '0;
    string       lit_name = "";

    always @(negedge clk) begin
        if (!reset_n)   m_reset();
        else if (s_rst) m_step();
        chk("readdata", bus.readdata, m_rd);
        chk("irq_vec", 16'(irq_vec), 16'(m_irqv()));
        chk("irq", 16'(irq), 16'(|m_irqv()));
        if (lit_seq != lit_done) begin
            lit_done = lit_seq;
            chk(lit_name, (lit_kind == 0) ? bus.readdata :
                          (lit_kind == 1) ? 16'(irq_vec) : 16'(irq), lit_val);
        end
    end

    task automatic post(input int kind, input logic [15:0] v, input string nm);
        lit_kind = kind; lit_val = v; lit_name = nm;
        lit_seq++;
        @(negedge clk); #1;
    endtask

    task automatic wr(input int ch, input int rg, input logic [15:0] d);
        bus.address = 5'(ch * 8 + rg);
        bus.writedata = d; bus.chipselect = 1'b1; bus.write_n = 1'b0;
        @(posedge clk); #1;
        bus.chipselect = 1'b0; bus.write_n = 1'b1;
    endtask

    task automatic rd_raw(input int ch, input int rg);
        bus.address = 5'(ch * 8 + rg);
        bus.chipselect = 1'b1; bus.write_n = 1'b1;
        @(posedge clk); #1;
        bus.chipselect = 1'b0;
    endtask

    task automatic rd(input int ch, input int rg, input logic [15:0] exp, input string nm);
        rd_raw(ch, rg);
        post(0, exp, nm);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        int r, c, g;
        logic [15:0] d;
        bus.address = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        rd(0, 2, 16'h869F, "rst_period_l");
        rd(0, 3, 16'h0001, "rst_period_h");
        rd(0, 0, 16'h0000, "rst_status");
        post(2, 16'h0, "rst_irq");

        // one-shot, period 5, no prescale: timeout 6 clocks after START
        wr(1, 2, 5); wr(1, 3, 0); wr(1, 6, 0); wr(1, 1, 16'h5);
        idle(5); post(1, 16'h0, "oneshot_early");
        idle(1); post(1, 16'h2, "oneshot_to");
        rd(1, 0, 16'h0001, "oneshot_status");
        wr(1, 0, 0); post(2, 16'h0, "oneshot_clear");

        // continuous, period 3, presc 2: timeout every 12 clocks
        wr(2, 2, 3); wr(2, 3, 0); wr(2, 6, 2); wr(2, 1, 16'h7);
        idle(11); post(1, 16'h0, "cont_early");
        idle(1);  post(1, 16'h4, "cont_to1");
        wr(2, 0, 0);
        idle(10); post(1, 16'h0, "cont_gap");
        idle(1);  post(1, 16'h4, "cont_to2");
        wr(2, 1, 16'h8);
        wr(2, 4, 0); rd(2, 4, 16'h0003, "stop_snap1");
        idle(8);
        wr(2, 4, 0); rd(2, 4, 16'h0003, "stop_snap2");

        // snapshot of a free-running counter starting at 0x10000
        wr(0, 2, 0); wr(0, 3, 1); wr(0, 6, 0); wr(0, 1, 16'h6);
        idle(9);
        wr(0, 4, 0);
        rd(0, 4, 16'hFFF7, "snap_l");
        rd(0, 5, 16'h0000, "snap_h");
        wr(0, 5, 0);
        rd(0, 4, 16'hFFF4, "snap_l_later");
        wr(0, 1, 16'h8);

        // status clear lands on the timeout cycle
        wr(1, 2, 2); wr(1, 3, 0); wr(1, 1, 16'h5);
        idle(2); wr(1, 0, 0);
        post(1, 16'h0, "clear_wins_irq");
        rd(1, 0, 16'h0000, "clear_wins_status");
        wr(1, 1, 16'hC);
        rd(1, 0, 16'h0002, "start_wins");
        wr(1, 1, 16'h8);

        // two channels interrupting together
        wr(0, 2, 1); wr(0, 3, 0); wr(0, 1, 16'h5);
        wr(3, 2, 1); wr(3, 3, 0); wr(3, 6, 0); wr(3, 1, 16'h5);
        idle(10); post(1, 16'h9, "multi_irq_vec");
        rd(2, 7, 16'h0009, "irq_pend_ch2");
        rd(3, 7, 16'h0009, "irq_pend_ch3");
        wr(0, 0, 0);
        post(1, 16'h8, "multi_clear_vec");
        post(2, 16'h1, "multi_clear_irq");

        // random traffic, small periods and prescales so timeouts are frequent
        repeat (2500) begin
            r = $urandom_range(0, 9);
            c = $urandom_range(0, NUM_CH - 1);
            g = $urandom_range(0, 7);
            if (r >= 8) begin
                d = 16'($urandom);
                case (g)
                    1: d = 16'($urandom_range(0, 15));
                    2: d = 16'($urandom_range(0, 20));
                    3: d = ($urandom_range(0, 15) == 0) ? 16'h1 : 16'h0;
                    6: d = 16'($urandom_range(0, 3));
                    default: ;
                endcase
                wr(c, g, d);
            end else if (r >= 6) begin
                rd_raw(c, g);
            end else begin
                idle(1);
            end
        end

        // asynchronous reset in the middle of a cycle
        wr(1, 2, 4); wr(1, 3, 0); wr(1, 1, 16'h7);
        idle(2);
        #3 reset_n = 1'b0;
        post(2, 16'h0, "async_rst_irq");
        @(posedge clk); #1 reset_n = 1'b1;
        rd(1, 2, 16'h869F, "post_rst_period");
        rd(1, 0, 16'h0000, "post_rst_status");

        repeat (2) @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
